// File: rtl/vx_ipdom_pkg.sv
// Shared types and constants for the multi-warp IPDOM reconvergence stack.
package vx_ipdom_pkg;

  localparam int IPDOM_WIDTH     = 32;
  localparam int IPDOM_DEPTH     = 8;
  localparam int IPDOM_NUM_WARPS = 4;

  localparam int WIDW  = (IPDOM_NUM_WARPS > 1) ? $clog2(IPDOM_NUM_WARPS) : 1;
  localparam int ADDRW = $clog2(IPDOM_DEPTH);
  localparam int CNTW  = ADDRW + 1;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef struct packed {
    logic [IPDOM_WIDTH-1:0] q2;
    logic [IPDOM_WIDTH-1:0] q1;
  } ipdom_entry_t;

  // A single warp still needs a one-bit id so ports never collapse to zero width.
  function automatic int widw_of(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/double_port_mem_wrapper.sv
// Simple dual-port storage: one synchronous write port, one combinational read port.
module double_port_mem_wrapper #(
  parameter  int DATAW = 64,
  parameter  int SIZE  = 32,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             wren,
  input  logic [AW-1:0]    waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wren) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vx_ipdom_stack_bank_warp_ctrl.sv
// Per-warp stack bookkeeping: occupancy counter, pair/part flags and empty/full status.
module vx_ipdom_warp_ctrl
  import vx_ipdom_pkg::*;
#(
  parameter  int DEPTH = IPDOM_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_en,
  input  logic          pop_en,
  input  logic          pair,
  input  logic          flush,
  output logic [CW-1:0] cnt,
  output logic          top_part,
  output logic          empty,
  output logic          full
);

  logic [DEPTH-1:0] part;
  logic [AW-1:0]    top_slot;
  logic [AW-1:0]    push_slot;

  assign top_slot  = AW'(cnt - 1'b1);
  assign push_slot = cnt[AW-1:0];
  assign top_part  = part[top_slot];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));

  // A part flag of 0 means the else-path half is still pending; the entry retires on the pop that sees 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      part <= '0;
    end else if (flush) begin
      cnt  <= '0;
      part <= '0;
    end else if (push_en) begin
      part[push_slot] <= ~pair;
      cnt             <= cnt + 1'b1;
    end else if (pop_en) begin
      if (!top_part) begin
        part[top_slot] <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_ipdom_stack_bank.sv
// NUM_WARPS independent IPDOM stacks sharing one storage array, with registered pop responses.
module vx_ipdom_stack_bank
  import vx_ipdom_pkg::*;
#(
  parameter  int WIDTH     = IPDOM_WIDTH,
  parameter  int DEPTH     = IPDOM_DEPTH,
  parameter  int NUM_WARPS = IPDOM_NUM_WARPS,
  localparam int LWIDW     = widw_of(NUM_WARPS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_push_i,
  input  logic [LWIDW-1:0]     req_wid_i,
  input  logic                 req_pair_i,
  input  logic [WIDTH-1:0]     req_q1_i,
  input  logic [WIDTH-1:0]     req_q2_i,
  input  logic                 flush_valid_i,
  input  logic [LWIDW-1:0]     flush_wid_i,
  output logic                 rsp_valid_o,
  output logic [LWIDW-1:0]     rsp_wid_o,
  output logic [WIDTH-1:0]     rsp_data_o,
  output logic                 rsp_index_o,
  output logic                 rsp_err_o,
  output logic [NUM_WARPS-1:0] empty_o,
  output logic [NUM_WARPS-1:0] full_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  localparam int LADDRW = $clog2(DEPTH);
  localparam int LCNTW  = LADDRW + 1;
  localparam int SIZE   = NUM_WARPS * DEPTH;
  localparam int MEMAW  = $clog2(SIZE);

  typedef struct packed {
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q1;
  } entry_t;

  logic [LCNTW-1:0]     cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] top_part;
  logic [NUM_WARPS-1:0] push_en;
  logic [NUM_WARPS-1:0] pop_en;
  logic [NUM_WARPS-1:0] flush_en;

  logic              accept;
  logic              is_push;
  logic [LCNTW-1:0]  sel_cnt;
  logic              sel_part;
  logic              sel_empty;
  logic              sel_full;
  logic [LADDRW-1:0] push_slot;
  logic [LADDRW-1:0] top_slot;
  logic [MEMAW-1:0]  base_addr;
  logic [MEMAW-1:0]  wr_addr;
  logic [MEMAW-1:0]  rd_addr;
  logic              mem_wren;
  entry_t            wr_entry;
  entry_t            rd_entry;

  assign req_ready_o = ~(flush_valid_i && (flush_wid_i == req_wid_i));
  assign accept      = req_valid_i & req_ready_o;
  assign is_push     = (req_push_i == OP_PUSH);

  assign sel_cnt   = cnt[req_wid_i];
  assign sel_part  = top_part[req_wid_i];
  assign sel_empty = empty_o[req_wid_i];
  assign sel_full  = full_o[req_wid_i];

  // Each warp owns a contiguous DEPTH-entry region; the warp id forms the upper address bits.
  assign push_slot = sel_cnt[LADDRW-1:0];
  assign top_slot  = LADDRW'(sel_cnt - 1'b1);
  assign base_addr = MEMAW'(req_wid_i) << LADDRW;
  assign wr_addr   = base_addr | MEMAW'(push_slot);
  assign rd_addr   = base_addr | MEMAW'(top_slot);

  assign wr_entry.q2 = req_q2_i;
  assign wr_entry.q1 = req_q1_i;
  assign mem_wren    = |push_en;

  double_port_mem_wrapper #(
    .DATAW (2 * WIDTH),
    .SIZE  (SIZE)
  ) u_mem (
    .clk   (clk_i),
    .wren  (mem_wren),
    .waddr (wr_addr),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic hit;

    assign hit         = (req_wid_i == LWIDW'(w));
    assign push_en[w]  = accept & is_push & hit & ~full_o[w];
    assign pop_en[w]   = accept & ~is_push & hit & ~empty_o[w];
    assign flush_en[w] = flush_valid_i & (flush_wid_i == LWIDW'(w));

    vx_ipdom_warp_ctrl #(
      .DEPTH (DEPTH)
    ) u_ctrl (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .push_en  (push_en[w]),
      .pop_en   (pop_en[w]),
      .pair     (req_pair_i),
      .flush    (flush_en[w]),
      .cnt      (cnt[w]),
      .top_part (top_part[w]),
      .empty    (empty_o[w]),
      .full     (full_o[w])
    );
  end

  // Storage reads combinationally, so registering here gives the one-cycle pop latency and
  // makes a push followed by a pop to the same warp see the freshly written entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_wid_o   <= '0;
      rsp_data_o  <= '0;
      rsp_index_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      ovf_o       <= 1'b0;
      udf_o       <= 1'b0;
    end else begin
      rsp_valid_o <= accept & ~is_push;
      if (accept && !is_push) begin
        rsp_wid_o <= req_wid_i;
        if (sel_empty) begin
          rsp_data_o  <= '0;
          rsp_index_o <= 1'b0;
          rsp_err_o   <= 1'b1;
          udf_o       <= 1'b1;
        end else begin
          rsp_data_o  <= sel_part ? rd_entry.q1 : rd_entry.q2;
          rsp_index_o <= sel_part;
          rsp_err_o   <= 1'b0;
        end
      end
      if (accept && is_push && sel_full) begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_ipdom_stack_bank.sv
// Scoreboard bench for vx_ipdom_stack_bank: expected pop responses queued at issue, checked on arrival.
module tb_vx_ipdom_stack_bank;

  localparam int WIDTH     = 32;
  localparam int NUM_WARPS = 4;

  typedef struct {
    logic [1:0]       wid;
    logic [WIDTH-1:0] data;
    logic             idx;
    logic             err;
  } rsp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic                 req_push_i = 1'b0;
  logic [1:0]           req_wid_i = '0;
  logic                 req_pair_i = 1'b0;
  logic [WIDTH-1:0]     req_q1_i = '0;
  logic [WIDTH-1:0]     req_q2_i = '0;
  logic                 flush_valid_i = 1'b0;
  logic [1:0]           flush_wid_i = '0;
  logic                 rsp_valid_o;
  logic [1:0]           rsp_wid_o;
  logic [WIDTH-1:0]     rsp_data_o;
  logic                 rsp_index_o;
  logic                 rsp_err_o;
  logic [NUM_WARPS-1:0] empty_o;
  logic [NUM_WARPS-1:0] full_o;
  logic                 ovf_o;
  logic                 udf_o;

  int   n_vectors = 0;
  int   n_miscompares = 0;
  rsp_t exp_q[$];

  vx_ipdom_stack_bank #(
    .WIDTH     (WIDTH),
    .DEPTH     (8),
    .NUM_WARPS (NUM_WARPS)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_push_i    (req_push_i),
    .req_wid_i     (req_wid_i),
    .req_pair_i    (req_pair_i),
    .req_q1_i      (req_q1_i),
    .req_q2_i      (req_q2_i),
    .flush_valid_i (flush_valid_i),
    .flush_wid_i   (flush_wid_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_wid_o     (rsp_wid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_index_o   (rsp_index_o),
    .rsp_err_o     (rsp_err_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .ovf_o         (ovf_o),
    .udf_o         (udf_o)
  );

  always #5 clk_i = ~clk_i;

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      n_vectors++;
      if (exp_q.size() == 0) begin
        n_miscompares++;
        $display("[TB] FAIL rsp_unexpected: got wid=%0d data=%h idx=%0d err=%0d, want no response",
                 rsp_wid_o, rsp_data_o, rsp_index_o, rsp_err_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_wid_o !== e.wid || rsp_data_o !== e.data || rsp_index_o !== e.idx || rsp_err_o !== e.err) begin
          n_miscompares++;
          $display("[TB] FAIL rsp: got wid=%0d data=%h idx=%0d err=%0d, want wid=%0d data=%h idx=%0d err=%0d",
                   rsp_wid_o, rsp_data_o, rsp_index_o, rsp_err_o, e.wid, e.data, e.idx, e.err);
        end
      end
    end
  end

  task automatic issue(input logic push, input logic [1:0] wid, input logic pair,
                       input logic [WIDTH-1:0] q1, input logic [WIDTH-1:0] q2);
    req_valid_i = 1'b1;
    req_push_i  = push;
    req_wid_i   = wid;
    req_pair_i  = pair;
    req_q1_i    = q1;
    req_q2_i    = q2;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_push(input logic [1:0] wid, input logic pair,
                         input logic [WIDTH-1:0] q1, input logic [WIDTH-1:0] q2);
    issue(1'b1, wid, pair, q1, q2);
  endtask

  task automatic do_pop(input logic [1:0] wid, input logic [WIDTH-1:0] data,
                        input logic idx, input logic err);
    rsp_t e;
    e.wid = wid; e.data = data; e.idx = idx; e.err = err;
    exp_q.push_back(e);
    issue(1'b0, wid, 1'b0, '0, '0);
  endtask

  task automatic check_bits(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vectors++;
    if (got !== want) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    check_bits("reset_empty", 32'(empty_o), 32'hF);
    check_bits("reset_full", 32'(full_o), 32'h0);
    check_bits("reset_flags", {29'd0, ovf_o, udf_o, rsp_valid_o}, 32'h0);
    check_bits("reset_rsp", rsp_data_o, 32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    do_pop(2'd0, '0, 1'b0, 1'b1);
    check_bits("udf_after_empty_pop", 32'(udf_o), 32'h1);
    check_bits("empty_after_empty_pop", 32'(empty_o), 32'hF);
  endtask

  task automatic test_pair;
    do_push(2'd2, 1'b1, 32'hA, 32'hB);
    check_bits("pair_not_empty", 32'(empty_o[2]), 32'h0);
    do_pop(2'd2, 32'hB, 1'b0, 1'b0);
    check_bits("pair_half_popped", 32'(empty_o[2]), 32'h0);
    do_pop(2'd2, 32'hA, 1'b1, 1'b0);
    check_bits("pair_retired", 32'(empty_o[2]), 32'h1);
    do_pop(2'd2, '0, 1'b0, 1'b1);
  endtask

  task automatic test_isolation;
    do_push(2'd1, 1'b0, 32'h11, 32'hEE);
    do_push(2'd3, 1'b1, 32'h31, 32'h33);
    check_bits("iso_empty", 32'(empty_o), 32'h5);
    do_pop(2'd1, 32'h11, 1'b1, 1'b0);
    do_pop(2'd3, 32'h33, 1'b0, 1'b0);
    do_pop(2'd3, 32'h31, 1'b1, 1'b0);
    check_bits("iso_drained", 32'(empty_o), 32'hF);
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) begin
      do_push(2'd0, 1'b0, 32'(i), 32'h80 + 32'(i));
    end
    check_bits("full_set", 32'(full_o), 32'h1);
    check_bits("ovf_before", 32'(ovf_o), 32'h0);
    do_push(2'd0, 1'b0, 32'h99, 32'h98);
    check_bits("ovf_after", 32'(ovf_o), 32'h1);
    check_bits("full_kept", 32'(full_o), 32'h1);
    for (int i = 7; i >= 0; i--) begin
      do_pop(2'd0, 32'(i), 1'b1, 1'b0);
    end
    check_bits("full_drained", {30'd0, full_o[0], empty_o[0]}, 32'h1);
  endtask

  task automatic test_back_to_back;
    do_push(2'd0, 1'b0, 32'h5, 32'h6);
    do_pop(2'd0, 32'h5, 1'b1, 1'b0);
    do_push(2'd1, 1'b1, 32'h41, 32'h42);
    req_valid_i   = 1'b1;
    req_push_i    = 1'b0;
    req_wid_i     = 2'd1;
    flush_valid_i = 1'b1;
    flush_wid_i   = 2'd1;
    #1;
    check_bits("flush_same_warp_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    req_valid_i   = 1'b0;
    flush_valid_i = 1'b0;
    check_bits("flush_cleared", 32'(empty_o[1]), 32'h1);
    do_push(2'd2, 1'b0, 32'h22, 32'h0);
    req_valid_i   = 1'b1;
    req_push_i    = 1'b1;
    req_wid_i     = 2'd3;
    req_pair_i    = 1'b0;
    req_q1_i      = 32'h77;
    req_q2_i      = 32'h78;
    flush_valid_i = 1'b1;
    flush_wid_i   = 2'd2;
    #1;
    check_bits("flush_other_ready", 32'(req_ready_o), 32'h1);
    @(posedge clk_i);
    #1;
    req_valid_i   = 1'b0;
    flush_valid_i = 1'b0;
    check_bits("flush_other_empty", 32'(empty_o), 32'h7);
    do_pop(2'd3, 32'h77, 1'b1, 1'b0);
    do_pop(2'd1, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_pop;
    do_push(2'd2, 1'b0, 32'h1, 32'h0);
    do_push(2'd2, 1'b0, 32'h2, 32'h0);
    do_push(2'd2, 1'b0, 32'h3, 32'h0);
    req_valid_i = 1'b1;
    req_push_i  = 1'b0;
    req_wid_i   = 2'd2;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    check_bits("midrst_no_rsp", 32'(rsp_valid_o), 32'h0);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    check_bits("midrst_no_rsp_after", 32'(rsp_valid_o), 32'h0);
    rst_ni = 1'b1;
    check_bits("midrst_empty", 32'(empty_o), 32'hF);
    check_bits("midrst_flags", {30'd0, ovf_o, udf_o}, 32'h0);
    do_pop(2'd2, '0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_pair();
    test_isolation();
    test_full();
    test_back_to_back();
    test_reset_mid_pop();
    repeat (3) @(negedge clk_i);
    n_vectors++;
    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL rsp_missing: got %0d responses outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
